mem_responder: RTL

- Responder (memory-side) end of the core's IMEM/DMEM request interface: accepts address/rmask/wmask/wdata requests and returns rdata with a one-cycle resp pulse after a configurable latency.
- Backed by an internal byte-writable word SRAM.
- One instance serves IMEM (wmask tied 0); a second serves DMEM.
- Used as the synthesizable memory model for pipeline bring-up and as the template for the future cache-side responder.

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/sram_byte_array.sv | 26 ++
 rtl/mem_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM states, latched request, counter sizing.
package mem_resp_pkg;

    localparam int MAX_LATENCY = 15;
    localparam int MAX_STALL   = 3;
    localparam int CNT_W       = $clog2(MAX_LATENCY + MAX_STALL + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_resp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Word-wide SRAM with synchronous read and four independent byte-write lanes.
module sram_byte_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one request, waits LATENCY cycles, then pulses resp.
// Optional MEM_RESPONDER_RANDOM_STALL_EN adds 0..3 LFSR-driven wait cycles per request.
//
// state | meaning
// IDLE  | waiting for rmask|wmask != 0; latches the request and loads the down-counter
// BUSY  | counting down the remaining latency; inputs ignored
// DONE  | resp cycle; read data presented, write lanes committed at the closing edge
import mem_resp_pkg::*;

module mem_responder #(
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  rmask,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp,
    output logic        proto_err
);

    mem_resp_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_load;
    mem_req_t          req_q, req_d;
    logic [31:0]       sram_rd;
    logic [ADDR_W-1:0] rd_word;

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign cnt_load    = CNT_W'(LATENCY - 1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (|(rmask | wmask)) begin
                    req_d.addr  = addr;
                    req_d.rmask = rmask;
                    req_d.wmask = wmask;
                    req_d.wdata = wdata;
                    cnt_d       = cnt_load;
                    state_d     = (cnt_load == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The synchronous read must be issued the cycle before DONE; with no wait
    // cycles that is the accepting IDLE cycle, when only the live address exists.
    assign rd_word = (state_q == IDLE) ? addr[ADDR_W+1:2] : req_q.addr[ADDR_W+1:2];

    sram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .rd_addr (rd_word),
        .rd_data (sram_rd),
        .wr_addr (req_q.addr[ADDR_W+1:2]),
        .wr_be   (resp ? req_q.wmask : 4'b0000),
        .wr_data (req_q.wdata)
    );

    // Outputs decode only flops (state, latched masks, SRAM read register).
    assign resp      = (state_q == DONE);
    assign proto_err = resp & (|req_q.rmask) & (|req_q.wmask);
    assign rdata     = resp ? (sram_rd & lane_mask(req_q.rmask)) : 32'h0;

    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0], req_q.addr[31:ADDR_W+2], req_q.addr[1:0]};

endmodule
